// File: rtl/jump_flush_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the jump/flush sequencer.
package jump_flush_ctrl_pkg;

  localparam int ADDR_WIDTH       = 32;
  localparam int FLUSH_CYCLES_DEF = 2;

  localparam logic [ADDR_WIDTH-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_HOLD  = 2'd2
  } ctrl_state_e;

  // Instruction fetch is word-aligned: drop the byte offset.
  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/jump_flush_ctrl.sv
// Redirect/flush sequencer: turns EX taken-branch results into a PC load plus
// an IF/ID flush window, and defers a branch that resolves while the pipeline
// is frozen by a hold request until the hold drops.
module jump_flush_ctrl
  import jump_flush_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  jump_enable_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  hold_req_i,
  output logic                  pc_load_o,
  output logic [ADDR_WIDTH-1:0] pc_target_o,
  output logic                  flush_o,
  output logic                  hold_o,
  output logic                  misalign_o,
  output logic [CNT_WIDTH-1:0]  redirect_cnt_o
);

  // Counter only ever holds values up to FLUSH_CYCLES-1.
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_CYCLES - 1);
  localparam ctrl_state_e    AFTER_LOAD   = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;

  ctrl_state_e           state;
  logic [FCW-1:0]        flush_cnt;
  logic                  pend;
  logic [ADDR_WIDTH-1:0] pend_addr;

  logic                  take_now;
  logic                  take_pend;
  logic                  load;
  logic                  capture;
  logic [ADDR_WIDTH-1:0] raw_tgt;

  // Redirect decode; everything is gated by reset so outputs read 0 while it is low.
  always_comb begin
    take_now  = rst_i && (state == S_RUN)  && jump_enable_i && !hold_req_i;
    take_pend = rst_i && (state == S_HOLD) && pend && !hold_req_i;
    load      = take_now || take_pend;
    capture   = rst_i && (state == S_RUN) && jump_enable_i && hold_req_i && !pend;
    raw_tgt   = take_pend ? pend_addr : jump_addr_i;
  end

  // Output drive: hold wins over redirect, flush persists through a hold in S_FLUSH.
  always_comb begin
    pc_load_o   = load;
    pc_target_o = load ? word_align(raw_tgt) : ZERO;
    flush_o     = rst_i && (load || (state == S_FLUSH));
    hold_o      = rst_i && hold_req_i;
    misalign_o  = load && (raw_tgt[1:0] != 2'b00);
  end

  // Sequencer state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= S_RUN;
    end else begin
      unique case (state)
        S_RUN: begin
          if (take_now)     state <= AFTER_LOAD;
          else if (capture) state <= S_HOLD;
        end
        S_FLUSH: begin
          if (!hold_req_i && flush_cnt == FCW'(1)) state <= S_RUN;
        end
        S_HOLD: begin
          if (!hold_req_i) state <= pend ? AFTER_LOAD : S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  // Flush window down-counter: reload on redirect, frozen under hold.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      flush_cnt <= '0;
    end else if (load) begin
      flush_cnt <= FLUSH_RELOAD;
    end else if (state == S_FLUSH && !hold_req_i && flush_cnt != '0) begin
      flush_cnt <= flush_cnt - FCW'(1);
    end
  end

  // Deferred target: first capture under hold wins, cleared when it issues.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend      <= 1'b0;
      pend_addr <= ZERO;
    end else if (capture) begin
      pend      <= 1'b1;
      pend_addr <= jump_addr_i;
    end else if (take_pend) begin
      pend      <= 1'b0;
    end
  end

  // Redirect performance counter, free-running wrap.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      redirect_cnt_o <= '0;
    end else if (load) begin
      redirect_cnt_o <= redirect_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_jump_flush_ctrl.sv
// Directed + random bench for jump_flush_ctrl against a cycle-level reference
// model built from redirect/flush/hold rules (owed flush cycles, deferred queue).
module tb_jump_flush_ctrl;

  localparam int FC = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          jump_enable_i = 1'b0;
  logic [31:0]   jump_addr_i = '0;
  logic          hold_req_i = 1'b0;
  logic          pc_load_o;
  logic [31:0]   pc_target_o;
  logic          flush_o;
  logic          hold_o;
  logic          misalign_o;
  logic [CW-1:0] redirect_cnt_o;

  jump_flush_ctrl #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .jump_enable_i  (jump_enable_i),
    .jump_addr_i    (jump_addr_i),
    .hold_req_i     (hold_req_i),
    .pc_load_o      (pc_load_o),
    .pc_target_o    (pc_target_o),
    .flush_o        (flush_o),
    .hold_o         (hold_o),
    .misalign_o     (misalign_o),
    .redirect_cnt_o (redirect_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int          flush_left = 0;  // flush cycles still owed after the redirect cycle
  logic [31:0] pend_q[$];       // branch deferred under hold
  int          m_cnt = 0;       // redirects issued so far

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check mid-cycle, then advance the model.
  task automatic step(input bit r, input bit je, input logic [31:0] a, input bit h);
    bit          e_load, e_flush, e_mis;
    logic [31:0] e_tgt;
    @(negedge clk);
    rst_i = r; jump_enable_i = je; jump_addr_i = a; hold_req_i = h;
    #1;
    e_load = 0; e_flush = 0; e_mis = 0; e_tgt = 0;
    if (!r) begin
      flush_left = 0; pend_q.delete(); m_cnt = 0;
      chk("rst_load", 32'(pc_load_o), 0);
      chk("rst_tgt", pc_target_o, 0);
      chk("rst_flush", 32'(flush_o), 0);
      chk("rst_hold", 32'(hold_o), 0);
      chk("rst_mis", 32'(misalign_o), 0);
      chk("rst_cnt", 32'(redirect_cnt_o), 0);
      return;
    end
    if (h) begin
      e_flush = (flush_left > 0);
      if (je && flush_left == 0 && pend_q.size() == 0) pend_q.push_back(a);
    end else begin
      if (pend_q.size() != 0) begin
        e_load = 1; e_tgt = pend_q.pop_front();
      end else if (je && flush_left == 0) begin
        e_load = 1; e_tgt = a;
      end
      e_flush = e_load || (flush_left > 0);
      if (e_load) flush_left = FC - 1;
      else if (flush_left > 0) flush_left--;
    end
    if (e_load) e_mis = (e_tgt % 4) != 0;
    chk("pc_load", 32'(pc_load_o), 32'(e_load));
    if (e_load) chk("pc_target", pc_target_o, e_tgt - (e_tgt % 4));
    chk("flush", 32'(flush_o), 32'(e_flush));
    chk("hold", 32'(hold_o), 32'(h));
    chk("misalign", 32'(misalign_o), 32'(e_mis));
    chk("redirect_cnt", 32'(redirect_cnt_o), 32'(m_cnt % (1 << CW)));
    chk("load_hold_excl", 32'(pc_load_o && hold_o), 0);
    if (e_load) m_cnt++;
  endtask

  initial begin
    // Reset state.
    step(0, 0, 0, 0);
    step(0, 1, 32'h40, 1);
    step(1, 0, 0, 0);
    // Plain jump: load 0x100, two flush cycles.
    step(1, 1, 32'h100, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // Jump under a 3-cycle hold, re-asserted jump ignored, then release.
    step(1, 1, 32'h200, 1);
    step(1, 1, 32'h300, 1);
    step(1, 1, 32'h300, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // Hold during the flush window stretches it.
    step(1, 1, 32'h400, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // Misaligned target.
    step(1, 1, 32'h106, 0);
    step(1, 0, 0, 0);
    // Spurious jump during flush is ignored.
    step(1, 1, 32'h500, 0);
    step(1, 1, 32'h600, 0);
    step(1, 0, 0, 0);
    // Reset mid-flush, and mid-hold with a pending target.
    step(1, 1, 32'h700, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 32'h800, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // Counter wrap: 16 redirects from zero return to 0.
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 32'h1000 + 32'(i * 4), 0);
      step(1, 0, 0, 0);
    end
    step(1, 0, 0, 0);
    chk("cnt_wrap", 32'(redirect_cnt_o), 0);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 2) == 0),
           $urandom,
           ($urandom_range(0, 3) == 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
